// File: rtl/ewb_cam_drain_pkg.sv
// ewb_cam_drain_pkg
//   Types and constants shared by the eviction write buffer and its
//   priority CAM.
//   Contents: ewb_state_t (drain FSM states), default tag width, and a
//   helper that derives the line-tag width from address/offset widths.
package ewb_cam_drain_pkg;

    typedef enum logic {
        EWB_IDLE,
        EWB_DRAIN
    } ewb_state_t;

    localparam int unsigned EWB_ADDR_W   = 32;
    localparam int unsigned EWB_OFFSET_W = 5;
    localparam int unsigned EWB_TAG_W    = EWB_ADDR_W - EWB_OFFSET_W;

    function automatic int unsigned ewb_tag_w(input int unsigned addr_w,
                                              input int unsigned offset_w);
        return addr_w - offset_w;
    endfunction

endpackage

// File: rtl/ewb_match.sv
// ewb_match
//   Youngest-first fully-associative tag match over a circular buffer.
//   Ports:
//     tags    in  DEPTH x TAG_W  stored line tags
//     valids  in  DEPTH          per-entry valid (caller may mask entries)
//     rd_ptr  in  PTR_W          head index (oldest entry)
//     key     in  TAG_W          search tag
//     hit     out 1              some valid entry matched
//     idx     out PTR_W          index of the youngest matching entry
module ewb_match
    import ewb_cam_drain_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = EWB_TAG_W
) (
    input  logic [DEPTH-1:0][TAG_W-1:0] tags,
    input  logic [DEPTH-1:0]            valids,
    input  logic [$clog2(DEPTH)-1:0]    rd_ptr,
    input  logic [TAG_W-1:0]            key,
    output logic                        hit,
    output logic [$clog2(DEPTH)-1:0]    idx
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] slot;

    // Walk from head towards tail; a later match overrides an earlier one,
    // so the surviving index is the one closest to the tail.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        slot = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot = rd_ptr + PTR_W'(k);
            if (valids[slot] && (tags[slot] == key)) begin
                hit = 1'b1;
                idx = slot;
            end
        end
    end

endmodule

// File: rtl/ewb_cam_drain.sv
// ewb_cam_drain
//   Eviction write buffer between L2 and memory. Holds up to DEPTH dirty
//   victim lines in a circular queue, answers combinational line lookups,
//   coalesces re-evictions, accepts in-place updates from the cache and
//   drains to memory under a watermark / idle-timer / flush policy.
//   Ports:
//     clk, rst                          clock, synchronous active-high reset
//     enq_valid_i/ready_o/addr_i/data_i victim line enqueue
//     lkp_addr_i -> lkp_hit_o/data_o    zero-latency lookup
//     upd_valid_i/addr_i/data_i         in-place line update, upd_hit_o ack
//     flush_i                           force draining until empty
//     mem_valid_o/addr_o/data_o, mem_yumi_i  head line to memory
//     empty_o, full_o, count_o          occupancy status
module ewb_cam_drain
    import ewb_cam_drain_pkg::*;
#(
    parameter int unsigned WIDTH       = 256,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned OFFSET_W    = 5,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HWM         = 6,
    parameter int unsigned IDLE_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid_i,
    output logic                       enq_ready_o,
    input  logic [ADDR_W-1:0]          enq_addr_i,
    input  logic [WIDTH-1:0]           enq_data_i,
    input  logic [ADDR_W-1:0]          lkp_addr_i,
    output logic                       lkp_hit_o,
    output logic [WIDTH-1:0]           lkp_data_o,
    input  logic                       upd_valid_i,
    input  logic [ADDR_W-1:0]          upd_addr_i,
    input  logic [WIDTH-1:0]           upd_data_i,
    output logic                       upd_hit_o,
    input  logic                       flush_i,
    output logic                       mem_valid_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [WIDTH-1:0]           mem_data_o,
    input  logic                       mem_yumi_i,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned TAG_W  = ewb_tag_w(ADDR_W, OFFSET_W);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);

    logic [DEPTH-1:0][TAG_W-1:0] tags;
    logic [WIDTH-1:0]            data [DEPTH];
    logic [DEPTH-1:0]            valid;
    logic [PTR_W-1:0]            rd_ptr, wr_ptr;
    logic [CNT_W-1:0]            count, count_next;
    logic [IDLE_W-1:0]           idle_cnt;
    ewb_state_t                  state, state_next;

    logic [TAG_W-1:0] lkp_tag, enq_tag, upd_tag;
    logic [DEPTH-1:0] head_mask, enq_valids, upd_valids;
    logic             lkp_hit, enq_hit, upd_hit;
    logic [PTR_W-1:0] lkp_idx, enq_idx, upd_idx;
    logic             yumi, enq_coal, enq_alloc;

    assign lkp_tag = lkp_addr_i[ADDR_W-1:OFFSET_W];
    assign enq_tag = enq_addr_i[ADDR_W-1:OFFSET_W];
    assign upd_tag = upd_addr_i[ADDR_W-1:OFFSET_W];

    // The offered head is frozen for coalescing, and is leaving the buffer
    // for updates in a yumi cycle; hide it from those searches.
    assign head_mask  = DEPTH'(1) << rd_ptr;
    assign enq_valids = mem_valid_o ? (valid & ~head_mask) : valid;
    assign upd_valids = yumi ? (valid & ~head_mask) : valid;

    ewb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_lkp_match (
        .tags(tags), .valids(valid), .rd_ptr(rd_ptr), .key(lkp_tag),
        .hit(lkp_hit), .idx(lkp_idx)
    );

    ewb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_enq_match (
        .tags(tags), .valids(enq_valids), .rd_ptr(rd_ptr), .key(enq_tag),
        .hit(enq_hit), .idx(enq_idx)
    );

    ewb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_upd_match (
        .tags(tags), .valids(upd_valids), .rd_ptr(rd_ptr), .key(upd_tag),
        .hit(upd_hit), .idx(upd_idx)
    );

    assign empty_o = (count == '0);
    assign full_o  = (count == CNT_W'(DEPTH));
    assign count_o = count;

    assign yumi        = mem_valid_o & mem_yumi_i;
    assign enq_ready_o = enq_hit | ~full_o;
    assign enq_coal    = enq_valid_i & enq_hit;
    // No bypass: a full buffer refuses allocation even with a same-cycle yumi.
    assign enq_alloc   = enq_valid_i & ~enq_hit & ~full_o;
    assign upd_hit_o   = upd_valid_i & upd_hit;
    assign count_next  = count + CNT_W'(enq_alloc) - CNT_W'(yumi);

    assign lkp_hit_o  = lkp_hit;
    assign lkp_data_o = lkp_hit ? data[lkp_idx] : '0;
    assign mem_addr_o = {tags[rd_ptr], {OFFSET_W{1'b0}}};
    assign mem_data_o = data[rd_ptr];

    // Payload storage, not reset. Enqueue writes come last so they win
    // over an update to the same entry.
    always_ff @(posedge clk) begin
        if (upd_hit_o) begin
            data[upd_idx] <= upd_data_i;
        end
        if (enq_coal) begin
            data[enq_idx] <= enq_data_i;
        end
        if (enq_alloc) begin
            data[wr_ptr] <= enq_data_i;
            tags[wr_ptr] <= enq_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            idle_cnt <= '0;
        end else begin
            if (enq_alloc) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (yumi) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            if ((state == EWB_IDLE) && !enq_valid_i && (count != '0)) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EWB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        mem_valid_o = 1'b0;
        case (state)
            EWB_IDLE: begin
                if ((count >= CNT_W'(HWM)) ||
                    (idle_cnt == IDLE_W'(IDLE_CYCLES - 1)) || flush_i) begin
                    state_next = EWB_DRAIN;
                end
            end
            EWB_DRAIN: begin
                mem_valid_o = (count != '0);
                // Also covers a flush issued while already empty.
                if (count_next == '0) begin
                    state_next = EWB_IDLE;
                end
            end
            default: state_next = EWB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ewb_cam_drain.sv
module tb_ewb_cam_drain;

    localparam int unsigned WIDTH       = 256;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned OFFSET_W    = 5;
    localparam int unsigned DEPTH       = 8;
    localparam int unsigned HWM         = 6;
    localparam int unsigned IDLE_CYCLES = 16;
    localparam int unsigned TAG_W       = ADDR_W - OFFSET_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              enq_valid_i;
    logic              enq_ready_o;
    logic [ADDR_W-1:0] enq_addr_i;
    logic [WIDTH-1:0]  enq_data_i;
    logic [ADDR_W-1:0] lkp_addr_i;
    logic              lkp_hit_o;
    logic [WIDTH-1:0]  lkp_data_o;
    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_addr_i;
    logic [WIDTH-1:0]  upd_data_i;
    logic              upd_hit_o;
    logic              flush_i;
    logic              mem_valid_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [WIDTH-1:0]  mem_data_o;
    logic              mem_yumi_i;
    logic              empty_o;
    logic              full_o;
    logic [$clog2(DEPTH):0] count_o;

    ewb_cam_drain #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W),
        .DEPTH(DEPTH), .HWM(HWM), .IDLE_CYCLES(IDLE_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
        .enq_addr_i(enq_addr_i), .enq_data_i(enq_data_i),
        .lkp_addr_i(lkp_addr_i), .lkp_hit_o(lkp_hit_o), .lkp_data_o(lkp_data_o),
        .upd_valid_i(upd_valid_i), .upd_addr_i(upd_addr_i),
        .upd_data_i(upd_data_i), .upd_hit_o(upd_hit_o),
        .flush_i(flush_i),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_yumi_i(mem_yumi_i),
        .empty_o(empty_o), .full_o(full_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // Reference: an ordered list of buffered lines, oldest first.
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] data;
    } line_t;

    line_t q[$];
    bit    draining;
    int    idle;
    int    n_checks;
    int    n_fail;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:OFFSET_W];
    endfunction

    // Youngest matching position in the list, optionally ignoring the head.
    function automatic int find_youngest(input logic [TAG_W-1:0] t, input bit skip_head);
        for (int i = q.size() - 1; i >= (skip_head ? 1 : 0); i--) begin
            if (q[i].tag == t) return i;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_line();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Ten distinct lines with random offsets so hits and coalescing are common.
    function automatic logic [ADDR_W-1:0] rnd_addr();
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom_range(1, 10)) << 12;
        a[OFFSET_W-1:0] = OFFSET_W'($urandom_range(0, 31));
        return a;
    endfunction

    task automatic drive_idle();
        enq_valid_i = 1'b0; enq_addr_i = '0; enq_data_i = '0;
        upd_valid_i = 1'b0; upd_addr_i = '0; upd_data_i = '0;
        lkp_addr_i  = '0;   flush_i    = 1'b0; mem_yumi_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        lkp_addr_i = 32'h0000_1000;
        rst = 1'b1;
        @(posedge clk);
        q.delete();
        draining = 1'b0;
        idle = 0;
        #1;
        rst = 1'b0;
        upd_valid_i = 1'b1;
        upd_addr_i  = 32'h0000_1000;
        #1;
        check_eq("rst_count", count_o, 0);
        check_eq("rst_empty", empty_o, 1);
        check_eq("rst_full", full_o, 0);
        check_eq("rst_mem_valid", mem_valid_o, 0);
        check_eq("rst_lkp_hit", lkp_hit_o, 0);
        check_eq("rst_upd_hit", upd_hit_o, 0);
        upd_valid_i = 1'b0;
    endtask

    task automatic run_phase(input int cycles, input int p_enq, input int p_yumi,
                             input int p_upd, input int p_flush);
        bit mv, yumi;
        int c0, ei, ui, li;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            mv = draining && (q.size() > 0);
            enq_valid_i = ($urandom_range(0, 99) < p_enq);
            enq_addr_i  = rnd_addr();
            enq_data_i  = rnd_line();
            upd_valid_i = ($urandom_range(0, 99) < p_upd);
            upd_addr_i  = rnd_addr();
            upd_data_i  = rnd_line();
            lkp_addr_i  = rnd_addr();
            flush_i     = ($urandom_range(0, 99) < p_flush);
            mem_yumi_i  = mv && ($urandom_range(0, 99) < p_yumi);
            yumi        = mem_yumi_i;
            #1;
            c0 = q.size();
            li = find_youngest(tag_of(lkp_addr_i), 1'b0);
            ei = enq_valid_i ? find_youngest(tag_of(enq_addr_i), mv) : -1;
            ui = upd_valid_i ? find_youngest(tag_of(upd_addr_i), yumi) : -1;

            check_eq("count", count_o, c0);
            check_eq("empty", empty_o, c0 == 0);
            check_eq("full", full_o, c0 == DEPTH);
            check_eq("mem_valid", mem_valid_o, mv);
            if (mv) begin
                check_eq("mem_addr", mem_addr_o, {q[0].tag, {OFFSET_W{1'b0}}});
                check_eq("mem_data", mem_data_o, q[0].data);
            end
            check_eq("lkp_hit", lkp_hit_o, li >= 0);
            check_eq("lkp_data", lkp_data_o, (li >= 0) ? q[li].data : '0);
            check_eq("enq_ready", enq_ready_o,
                     (find_youngest(tag_of(enq_addr_i), mv) >= 0) || (c0 < DEPTH));
            if (upd_valid_i) check_eq("upd_hit", upd_hit_o, ui >= 0);

            @(posedge clk);
            if (ui >= 0) q[ui].data = upd_data_i;
            if (ei >= 0) begin
                q[ei].data = enq_data_i;
            end else if (enq_valid_i && c0 < DEPTH) begin
                q.push_back('{tag: tag_of(enq_addr_i), data: enq_data_i});
            end
            if (yumi) void'(q.pop_front());
            if (!draining) begin
                if (c0 >= HWM || idle == IDLE_CYCLES - 1 || flush_i) draining = 1'b1;
                if (enq_valid_i || c0 == 0) idle = 0;
                else idle++;
            end else if (q.size() == 0) begin
                draining = 1'b0;
                idle = 0;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        do_reset();
        run_phase(500, 70, 60, 30, 2);   // mixed traffic, watermark drains
        do_reset();
        run_phase(500, 90, 20, 30, 1);   // runs full, no-bypass rejects
        do_reset();
        run_phase(300, 60, 50, 30, 0);
        do_reset();                      // likely mid-drain
        run_phase(600, 6, 40, 40, 0);    // sparse enqueues, idle-timer drains
        do_reset();
        run_phase(500, 50, 90, 30, 3);   // fast drain, pointer wrap
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
